// File: rtl/mux_rr_sequencer.sv
// Round-robin select sequencer for a 4-channel mux: grants a requesting channel,
// waits SETTLE cycles, captures Y and presents it on a valid/ready stage.
// Optional: define SEL_PARK_EN to keep the select lines on the last channel while idle.
module mux_rr_sequencer #(
  parameter int SETTLE = 1   // legal 1..8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic       S1,
  output logic       S0,
  input  logic [3:0] Y,
  output logic [3:0] out_data,
  output logic [1:0] out_ch,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] req_ack
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;

  localparam logic [2:0] CNT_INIT = 3'(SETTLE - 1);

  state_t     state, state_n;
  logic [1:0] sel, sel_n;
  logic [1:0] last, last_n;
  logic [2:0] cnt, cnt_n;
  logic [3:0] data_n;
  logic [1:0] ch_n;
  logic       vld_n;
  logic [3:0] ack_n;
  logic [1:0] win;
  logic [1:0] idx;
  logic       found;

  // Search last+1, last+2, last+3, last; last itself wins only if it is alone.
  always_comb begin
    win   = last;
    found = 1'b0;
    idx   = last;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sel       <= 2'd0;
      last      <= 2'd3;
      cnt       <= 3'd0;
      out_data  <= 4'd0;
      out_ch    <= 2'd0;
      out_valid <= 1'b0;
      req_ack   <= 4'd0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      last      <= last_n;
      cnt       <= cnt_n;
      out_data  <= data_n;
      out_ch    <= ch_n;
      out_valid <= vld_n;
      req_ack   <= ack_n;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    last_n  = last;
    cnt_n   = cnt;
    data_n  = out_data;
    ch_n    = out_ch;
    vld_n   = out_valid;
    ack_n   = 4'd0;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          sel_n   = win;
          cnt_n   = CNT_INIT;
          state_n = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt != 3'd0) begin
          cnt_n = cnt - 3'd1;
        end else begin
          data_n  = Y;
          ch_n    = sel;
          vld_n   = 1'b1;
          ack_n   = 4'b0001 << sel;
          state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          vld_n   = 1'b0;
          last_n  = out_ch;
          state_n = ST_IDLE;
`ifdef SEL_PARK_EN
          sel_n   = sel;
`else
          sel_n   = 2'd0;
`endif
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    S1 = sel[1];
    S0 = sel[0];
  end

endmodule

// File: tb/tb_mux_rr_sequencer.sv
// Scoreboard bench for mux_rr_sequencer: two instances (SETTLE=1 with a modelled
// mux, SETTLE=4 with a bench-driven Y) checked by independent monitors.
module tb_mux_rr_sequencer;

  typedef struct {int ch; int data; int at;} exp_t;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  logic       rst1, s1_1, s0_1, ov1, rdy1;
  logic [3:0] req1, y1, od1, ack1;
  logic [1:0] oc1;
  logic       rst4, s1_4, s0_4, ov4, rdy4;
  logic [3:0] req4, y4, od4, ack4;
  logic [1:0] oc4;

  exp_t q1[$];
  exp_t q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mux model: A=1, B=2, C=3, D=4
  assign y1 = 4'({s1_1, s0_1}) + 4'd1;

  mux_rr_sequencer #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst1), .req(req1), .S1(s1_1), .S0(s0_1), .Y(y1),
    .out_data(od1), .out_ch(oc1), .out_valid(ov1), .out_ready(rdy1), .req_ack(ack1));

  mux_rr_sequencer #(.SETTLE(4)) dut4 (
    .clk(clk), .rst_n(rst4), .req(req4), .S1(s1_4), .S0(s0_4), .Y(y4),
    .out_data(od4), .out_ch(oc4), .out_valid(ov4), .out_ready(rdy4), .req_ack(ack4));

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic monitor_step(input string tag, input bit rise, input int ch, input int data,
                              input int ack, inout exp_t q[$]);
    exp_t e;
    if (rise) begin
      if (q.size() == 0) begin
        chk({tag, " unexpected sample"}, 1, 0);
      end else begin
        e = q.pop_front();
        chk({tag, " out_ch"}, ch, e.ch);
        chk({tag, " out_data"}, data, e.data);
        chk({tag, " req_ack"}, ack, 1 << e.ch);
        if (e.at >= 0) chk({tag, " capture cycle"}, cyc, e.at);
      end
    end else if (ack != 0) begin
      chk({tag, " stray req_ack"}, ack, 0);
    end
  endtask

  initial begin : mon1
    bit pv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst1) pv = 1'b0;
      else begin
        monitor_step("d1", ov1 && !pv, int'(oc1), int'(od1), int'(ack1), q1);
        pv = ov1;
      end
    end
  end

  initial begin : mon4
    bit pv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst4) pv = 1'b0;
      else begin
        monitor_step("d4", ov4 && !pv, int'(oc4), int'(od4), int'(ack4), q4);
        pv = ov4;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_q1(input int budget);
    for (int i = 0; i < budget && q1.size() != 0; i++) tick();
    if (q1.size() != 0) begin
      chk("d1 timeout waiting for sample", int'(q1.size()), 0);
      q1.delete();
    end
  endtask

  task automatic wait_q4(input int budget);
    for (int i = 0; i < budget && q4.size() != 0; i++) tick();
    if (q4.size() != 0) begin
      chk("d4 timeout waiting for sample", int'(q4.size()), 0);
      q4.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int park_exp;
    rst1 = 1'b1; rst4 = 1'b1;
    req1 = 4'd0; req4 = 4'd0; rdy1 = 1'b1; rdy4 = 1'b1; y4 = 4'd0;
    #2;
    rst1 = 1'b0; rst4 = 1'b0;

    // Reset and idle
    repeat (3) tick();
    chk("rst S1S0", int'({s1_1, s0_1}), 0);
    chk("rst out_data", int'(od1), 0);
    chk("rst out_ch", int'(oc1), 0);
    chk("rst out_valid", int'(ov1), 0);
    chk("rst req_ack", int'(ack1), 0);
    chk("rst d4 out_valid", int'(ov4), 0);
    rst1 = 1'b1; rst4 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle out_valid", int'(ov1), 0);
      chk("idle S1S0", int'({s1_1, s0_1}), 0);
    end

    // Single request on channel C
    k = cyc;
    q1.push_back('{2, 3, k + 2});
    req1 = 4'b0100;
    tick();
    chk("grant S1S0", int'({s1_1, s0_1}), 2);
    req1 = 4'd0;
    wait_q1(10);
    repeat (3) tick();

    // Fairness from a fresh reset (channel A first)
    rst1 = 1'b0;
    tick();
    rst1 = 1'b1;
    tick();
    k = cyc;
    for (int i = 0; i < 6; i++) q1.push_back('{i % 4, (i % 4) + 1, k + 2 + 3 * i});
    req1 = 4'b1111;
    wait_q1(40);
    req1 = 4'd0;
    repeat (3) tick();

    // Backpressure: last=1, so D beats A
    rdy1 = 1'b0;
    req1 = 4'b1001;
    q1.push_back('{3, 4, -1});
    wait_q1(20);
    for (int i = 0; i < 5; i++) begin
      chk("bp out_valid", int'(ov1), 1);
      chk("bp out_data", int'(od1), 4);
      chk("bp out_ch", int'(oc1), 3);
      chk("bp S1S0", int'({s1_1, s0_1}), 3);
      tick();
    end
    q1.push_back('{0, 1, -1});
    rdy1 = 1'b1;
    tick();
    chk("bp accepted", int'(ov1), 0);
    wait_q1(20);
    req1 = 4'd0;
    repeat (3) tick();

    // Serve B so last=1 before the mid-operation reset
    req1 = 4'b0010;
    q1.push_back('{1, 2, -1});
    wait_q1(20);
    req1 = 4'd0;
    repeat (3) tick();

    // Reset during SETTLE, then re-arbitrate from last=3
    req1 = 4'b0100;
    tick();
    chk("pre-reset grant S1S0", int'({s1_1, s0_1}), 2);
    rst1 = 1'b0;
    #1;
    chk("async rst S1S0", int'({s1_1, s0_1}), 0);
    chk("async rst out_valid", int'(ov1), 0);
    chk("async rst req_ack", int'(ack1), 0);
    req1 = 4'b1010;
    q1.push_back('{1, 2, -1});
    tick();
    rst1 = 1'b1;
    wait_q1(20);
    req1 = 4'd0;
`ifdef SEL_PARK_EN
    park_exp = 1;
`else
    park_exp = 0;
`endif
    tick();
    chk("park S1S0 after accept", int'({s1_1, s0_1}), park_exp);
    repeat (3) tick();
    chk("park S1S0 idle", int'({s1_1, s0_1}), park_exp);

    // Settle window on the SETTLE=4 instance: only the capture-edge Y counts
    k = cyc;
    q4.push_back('{1, 9, k + 5});
    req4 = 4'b0010;
    y4 = 4'd5;
    tick();
    chk("d4 grant S1S0", int'({s1_4, s0_4}), 1);
    req4 = 4'd0;
    tick();
    y4 = 4'd9;
    wait_q4(20);
    repeat (3) tick();
    chk("d4 queue drained", int'(q1.size() + q4.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_rr_sequencer.md
# mux_rr_sequencer

Round-robin select sequencer that drives the S1/S0 select lines of the 4-channel, 4-bit mux and samples its Y output. Requesting channels are served in rotating order. The mux output is captured after a programmable settle time and handed downstream through a valid/ready register stage. The block sits directly upstream of the mux on the select path and directly downstream of it on the data path.

## Interface
- SETTLE, 1: cycles from select change to Y capture; legal range 1..8; 0 is illegal.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  4  level request per channel; bit 0 = A (sel 00), 1 = B (01), 2 = C (10), 3 = D (11).
- S1  out  1  mux select MSB, registered.
- S0  out  1  mux select LSB, registered.
- Y  in  4  mux output, returned from the mux.
- out_data  out  4  captured sample.
- out_ch  out  2  channel index of out_data.
- out_valid  out  1  out_data/out_ch valid.
- out_ready  in  1  downstream accepts when high with out_valid.
- req_ack  out  4  one-cycle one-hot pulse on the capture edge for the served channel.

## Operation
- FSM states: IDLE, SETTLE, HOLD. Registers: sel[1:0] (= {S1,S0}), last[1:0], cnt[2:0].
- IDLE:
  - If req != 0, winner = first set bit searching last+1, last+2, ... (mod 4).
  - sel <= winner; cnt <= SETTLE-1; go SETTLE.
  - If req == 0, stay in IDLE.
- SETTLE:
  - cnt != 0: cnt <= cnt-1.
  - cnt == 0: out_data <= Y, out_ch <= sel, out_valid <= 1, req_ack[sel] <= 1 for one cycle; go HOLD.
- HOLD:
  - out_valid, out_data, out_ch and sel are held stable.
  - On an edge with out_ready=1: out_valid <= 0, last <= out_ch; go IDLE.
- req is sampled only in IDLE. Deassertion during SETTLE/HOLD does not abort the transaction; the capture and handshake complete.
- No new grant is issued while out_valid=1.
- Round-robin wrap: last=3 searches 0,1,2,3.
- If only the last-served channel requests, it is granted again.
- cnt is 3 bits, so SETTLE-1 ≤ 7.

## Timing
- Reset (rst_n low, asynchronous): S1=S0=0, out_data=0, out_ch=0, out_valid=0, req_ack=0, state=IDLE, cnt=0, last=3.
  - With last=3, channel A has first priority after reset.
- Reset asserted mid-transaction clears immediately. No partial sample is ever presented.
- Latency, req (sampled at edge E0 in IDLE) to out_valid: SETTLE+1 edges. Select is valid from E0; capture is at E0+SETTLE.
- Y is sampled at the capture edge only; earlier Y values are ignored.
- Throughput with out_ready held high: one sample every SETTLE+2 cycles (grant, SETTLE cycles, accept).
- req_ack pulses high on exactly the cycle out_valid first rises.

## Configuration
- SEL_PARK_EN:
  - Defined: in IDLE, S1/S0 keep the last granted channel (select parks, no toggling when idle).
  - Undefined: on the accept edge (HOLD→IDLE), sel <= 00, so the mux idles on channel A.
  - Both variants have identical grant order, latency and handshake.

## Test plan
- Reset and idle: hold rst_n low 3 cycles → all outputs 0. Release with req=0 for 10 cycles → out_valid=0, S1S0=00.
- Single request, SETTLE=1, mux model A=1, B=2, C=3, D=4, out_ready=1. req=0100 → S1S0=10 after the grant edge; next edge out_valid=1, out_data=3, out_ch=2, req_ack=0100 for one cycle.
- Fairness: req=1111 held, out_ready=1 → out_ch sequence 0,1,2,3,0,1, each sample spaced 3 cycles apart.
- Backpressure: out_ready=0 for 5 cycles after capture → out_valid stays 1, out_data/out_ch/S1S0 stable, no req_ack. Raise out_ready → accepted; next grant is the following channel.
- Settle window: SETTLE=4, req=0010. Drive B=5 at grant, change to B=9 two cycles later → out_data=9, out_valid rises 4 edges after grant.
- Reset mid-operation: assert rst_n during SETTLE → outputs clear asynchronously. After release with req=1010 → first grant is channel 1, not 3. Park check: without SEL_PARK_EN, S1S0=00 after accept; with it defined, S1S0 holds 01.
